// File: rtl/mem_stage_pkg.sv
// -----------------------------------------------------------------------------
// mem_stage_pkg
// Shared definitions for the RV32I memory-access stage: inst_type constants,
// FSM state encoding, reset constants for the write-back outputs and the
// access-size decode (returns the index of the last byte, i.e. size-1).
// -----------------------------------------------------------------------------
package mem_stage_pkg;

  localparam int TYPE_W_C = 6;

  localparam logic [5:0] NOP = 6'd0;
  localparam logic [5:0] LB  = 6'd1;
  localparam logic [5:0] LH  = 6'd2;
  localparam logic [5:0] LW  = 6'd3;
  localparam logic [5:0] LBU = 6'd4;
  localparam logic [5:0] LHU = 6'd5;
  localparam logic [5:0] SB  = 6'd6;
  localparam logic [5:0] SH  = 6'd7;
  localparam logic [5:0] SW  = 6'd8;

  localparam logic [31:0] ZeroWord    = 32'h0000_0000;
  localparam logic [4:0]  NOPRegAdder = 5'h00;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } mem_state_e;

  // Index of the final byte of an access: 0 for byte, 1 for half, 3 for word.
  function automatic logic [1:0] last_idx(input logic [5:0] inst_type);
    case (inst_type)
      LB, LBU, SB: last_idx = 2'd0;
      LH, LHU, SH: last_idx = 2'd1;
      LW, SW:      last_idx = 2'd3;
      default:     last_idx = 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/mem_load_ext.sv
// -----------------------------------------------------------------------------
// mem_load_ext
// Combinational sign/zero extender for assembled load data.
// Ports:
//   inst_type  in  6   load type (LB/LBU/LH/LHU sign/zero extend, others pass)
//   word       in  32  little-endian assembled value, byte 0 in [7:0]
//   result     out 32  extended write-back value
// -----------------------------------------------------------------------------
module mem_load_ext
  import mem_stage_pkg::*;
(
  input  logic [5:0]  inst_type,
  input  logic [31:0] word,
  output logic [31:0] result
);

  // Pick the extension rule from load width and signedness
  always_comb begin
    result = word;
    case (inst_type)
      LB:      result = {{24{word[7]}}, word[7:0]};
      LBU:     result = {24'h00_0000, word[7:0]};
      LH:      result = {{16{word[15]}}, word[15:0]};
      LHU:     result = {16'h0000, word[15:0]};
      default: result = word;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// -----------------------------------------------------------------------------
// mem_stage
// Memory-access stage of the 5-stage RV32I pipeline. Non-memory instructions
// pass straight through; loads/stores are serialised into byte transfers on
// the memory-controller port (little-endian) while stall_req_out is held.
// Optional build macro: MEM_MISALIGN_CHK_EN (adds misalign_out and skips the
// memory traffic for misaligned halfword/word accesses).
// Ports:
//   clk_in, rst_in (async active-low), rdy_in (low freezes all state)
//   stall_in[4]           MEM/WB held: keeps DONE stable
//   rd_in/rd_val_in/rd_addr_in/inst_type_in/load_in/store_in/mem_addr_in/
//   mem_val_in            from EX/MEM
//   rd_out/rd_val_out/rd_addr_out   to MEM/WB
//   stall_req_out         stall request to the pipeline controller
//   mctl_req_out/mctl_we_out/mctl_addr_out/mctl_data_out   byte request
//   mctl_data_in/mctl_ack_in        byte completion from the controller
//   misalign_out          (macro only) misaligned access flag in DONE
// -----------------------------------------------------------------------------
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int TYPE_W = 6
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              rdy_in,
  input  logic [5:0]        stall_in,
  input  logic              rd_in,
  input  logic [DATA_W-1:0] rd_val_in,
  input  logic [4:0]        rd_addr_in,
  input  logic [TYPE_W-1:0] inst_type_in,
  input  logic              load_in,
  input  logic              store_in,
  input  logic [ADDR_W-1:0] mem_addr_in,
  input  logic [DATA_W-1:0] mem_val_in,
  output logic              rd_out,
  output logic [DATA_W-1:0] rd_val_out,
  output logic [4:0]        rd_addr_out,
  output logic              stall_req_out,
  output logic              mctl_req_out,
  output logic              mctl_we_out,
  output logic [ADDR_W-1:0] mctl_addr_out,
  output logic [7:0]        mctl_data_out,
  input  logic [7:0]        mctl_data_in,
  input  logic              mctl_ack_in
`ifdef MEM_MISALIGN_CHK_EN
  ,
  output logic              misalign_out
`endif
);

  mem_state_e        state_r, state_s;
  logic [1:0]        idx_r;
  logic [23:0]       buf_r;
  logic [31:0]       res_r;
  logic [31:0]       word_s;
  logic [31:0]       ext_s;
  logic [1:0]        last_s;
  logic              mem_op_s;
  logic              is_load_s;
  logic              mis_s;
  logic              mis_done_s;
  logic              unused_stall_s;

  assign mem_op_s       = load_in | store_in;
  // Load and store both set is a store.
  assign is_load_s      = load_in & ~store_in;
  assign last_s         = last_idx(inst_type_in);
  assign unused_stall_s = ^{stall_in[5], stall_in[3:0]};

`ifdef MEM_MISALIGN_CHK_EN
  logic mis_r;
  assign mis_s = mem_op_s &
                 (((last_s == 2'd1) && mem_addr_in[0]) ||
                  ((last_s == 2'd3) && (mem_addr_in[1:0] != 2'b00)));
  assign mis_done_s   = mis_r;
  assign misalign_out = (state_r == ST_DONE) & mis_r;

  // Remember whether the access entering DONE was rejected as misaligned
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      mis_r <= 1'b0;
    end else if (rdy_in && (state_r == ST_IDLE)) begin
      mis_r <= mis_s;
    end else begin
      mis_r <= mis_r;
    end
  end
`else
  assign mis_s      = 1'b0;
  assign mis_done_s = 1'b0;
`endif

  // Full word as it will stand once the byte currently on mctl_data_in lands
  always_comb begin
    word_s = {8'h00, buf_r};
    case (idx_r)
      2'd0:    word_s[7:0]   = mctl_data_in;
      2'd1:    word_s[15:8]  = mctl_data_in;
      2'd2:    word_s[23:16] = mctl_data_in;
      2'd3:    word_s[31:24] = mctl_data_in;
      default: word_s = {8'h00, buf_r};
    endcase
  end

  mem_load_ext u_ext (
    .inst_type (inst_type_in),
    .word      (res_r),
    .result    (ext_s)
  );

  // Next-state logic
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (mem_op_s) begin
          state_s = mis_s ? ST_DONE : ST_ACCESS;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_ACCESS: begin
        if (mctl_ack_in && (idx_r == last_s)) begin
          state_s = ST_DONE;
        end else begin
          state_s = ST_ACCESS;
        end
      end
      ST_DONE: begin
        if (!stall_in[4]) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_DONE;
        end
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // State, byte counter, upper-byte buffer and registered load result
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_r <= ST_IDLE;
      idx_r   <= 2'd0;
      buf_r   <= 24'h00_0000;
      res_r   <= 32'h0000_0000;
    end else if (rdy_in) begin
      state_r <= state_s;
      case (state_r)
        ST_IDLE: idx_r <= 2'd0;
        ST_ACCESS: begin
          if (mctl_ack_in) begin
            idx_r <= idx_r + 2'd1;
            if (is_load_s) begin
              case (idx_r)
                2'd0:    buf_r[7:0]   <= mctl_data_in;
                2'd1:    buf_r[15:8]  <= mctl_data_in;
                2'd2:    buf_r[23:16] <= mctl_data_in;
                default: buf_r        <= buf_r;
              endcase
              // The final byte goes straight into the result register.
              if (idx_r == last_s) begin
                res_r <= word_s;
              end
            end
          end
        end
        default: idx_r <= idx_r;
      endcase
    end
  end

  // Output decode; everything is forced quiet while reset is asserted
  always_comb begin
    rd_out        = 1'b0;
    rd_val_out    = ZeroWord;
    rd_addr_out   = NOPRegAdder;
    stall_req_out = 1'b0;
    mctl_req_out  = 1'b0;
    mctl_we_out   = 1'b0;
    mctl_addr_out = {ADDR_W{1'b0}};
    mctl_data_out = 8'h00;
    if (rst_in) begin
      rd_addr_out = rd_addr_in;
      rd_val_out  = rd_val_in;
      case (state_r)
        ST_IDLE: begin
          if (mem_op_s) begin
            stall_req_out = 1'b1;
          end else begin
            rd_out = rd_in;
          end
        end
        ST_ACCESS: begin
          stall_req_out = 1'b1;
          mctl_req_out  = 1'b1;
          mctl_we_out   = store_in;
          mctl_addr_out = mem_addr_in + {{(ADDR_W-2){1'b0}}, idx_r};
          case (idx_r)
            2'd0:    mctl_data_out = mem_val_in[7:0];
            2'd1:    mctl_data_out = mem_val_in[15:8];
            2'd2:    mctl_data_out = mem_val_in[23:16];
            2'd3:    mctl_data_out = mem_val_in[31:24];
            default: mctl_data_out = 8'h00;
          endcase
        end
        ST_DONE: begin
          if (is_load_s && !mis_done_s) begin
            rd_out     = rd_in;
            rd_val_out = ext_s;
          end else begin
            rd_out = 1'b0;
          end
        end
        default: rd_out = 1'b0;
      endcase
    end else begin
      rd_out = 1'b0;
    end
  end

endmodule
